// File: rtl/cell_pos_arbiter.sv
// cell_pos_arbiter
// Shares one single-port cell position RAM between a full-cell read sweep
// (force evaluation) and single-word write-back (motion update).
// RAM layout: address 0 = particle count, 1..count = {posz, posy, posx}.
// RAM read latency is 2 cycles.
//
// Ports
//   clk, rst_n        clock (rising edge), async active-low reset
//   rd_req            level request for a sweep, held until rd_busy rises
//   rd_busy           sweep in progress (CNT_RD..DONE)
//   rd_valid/rd_data/rd_index/rd_last   streamed particles, address order
//   rd_done           one-cycle end-of-sweep pulse
//   cell_count        clamped count latched by the current/last sweep
//   count_err         sticky: stored count exceeded PARTICLE_NUM-1
//   wr_valid/wr_ready/wr_addr/wr_data   write-back handshake
//   mem_*             RAM address/data/rden/wren and read data mem_q
//
// Build option
//   CELL_ARB_WR_PRIO_EN : writes win in IDLE; a held rd_req waits for a
//                         cycle with wr_valid low. Default is read priority.
module cell_pos_arbiter #(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_req,
    output logic                  rd_busy,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] rd_index,
    output logic                  rd_last,
    output logic                  rd_done,
    output logic [ADDR_WIDTH-1:0] cell_count,
    output logic                  count_err,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    localparam logic [ADDR_WIDTH-1:0] MAX_IDX = ADDR_WIDTH'(PARTICLE_NUM - 1);

    typedef enum logic [2:0] {IDLE, CNT_RD, CNT_WAIT, STREAM, DRAIN, DONE} state_t;

    state_t                            state_q, state_d;
    logic                              wait_q, wait_d;
    logic [ADDR_WIDTH-1:0]             addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]             cell_count_q, cell_count_d;
    logic                              count_err_q, count_err_d;
    logic                              wr_pend_q, wr_pend_d;
    logic [ADDR_WIDTH-1:0]             wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]             wr_data_q, wr_data_d;
    // Read tag pipeline: index 0 = one cycle after issue, 1 = aligned with mem_q.
    logic [1:0]                        tag_vld_q, tag_vld_d;
    logic [1:0]                        tag_last_q, tag_last_d;
    logic [1:0][ADDR_WIDTH-1:0]        tag_idx_q, tag_idx_d;
    logic                              tag_in_vld, tag_in_last;
    logic [ADDR_WIDTH-1:0]             tag_in_idx;

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        addr_d       = addr_q;
        cell_count_d = cell_count_q;
        count_err_d  = count_err_q;
        wr_pend_d    = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        tag_in_vld   = 1'b0;
        tag_in_last  = 1'b0;
        tag_in_idx   = '0;
        wr_ready     = 1'b0;
        mem_rden     = 1'b0;
        mem_wren     = 1'b0;
        mem_address  = '0;
        mem_data     = '0;

        // An accepted write always lands in the IDLE cycle after its handshake,
        // so it never collides with a read issue.
        if (wr_pend_q) begin
            mem_wren    = 1'b1;
            mem_address = wr_addr_q;
            mem_data    = wr_data_q;
        end

        case (state_q)
            IDLE: begin
                // rst_n gating keeps wr_ready low while reset is asserted.
`ifdef CELL_ARB_WR_PRIO_EN
                wr_ready = rst_n;
`else
                wr_ready = rst_n & ~rd_req;
`endif
                if (wr_valid && wr_ready) begin
                    wr_pend_d = 1'b1;
                    wr_addr_d = wr_addr;
                    wr_data_d = wr_data;
                end else if (rd_req) begin
                    state_d     = CNT_RD;
                    count_err_d = 1'b0;
                end
            end
            CNT_RD: begin
                mem_rden = 1'b1;
                wait_d   = 1'b0;
                state_d  = CNT_WAIT;
            end
            CNT_WAIT: begin
                if (!wait_q) begin
                    wait_d = 1'b1;
                end else begin
                    if (mem_q[ADDR_WIDTH-1:0] > MAX_IDX) begin
                        cell_count_d = MAX_IDX;
                        count_err_d  = 1'b1;
                    end else begin
                        cell_count_d = mem_q[ADDR_WIDTH-1:0];
                    end
                    addr_d  = ADDR_WIDTH'(1);
                    state_d = (mem_q[ADDR_WIDTH-1:0] == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                mem_rden    = 1'b1;
                mem_address = addr_q;
                tag_in_vld  = 1'b1;
                tag_in_idx  = addr_q;
                tag_in_last = (addr_q == cell_count_q);
                if (tag_in_last) state_d = DRAIN;
                else             addr_d  = addr_q + 1'b1;
            end
            DRAIN: begin
                // Once stage 0 is empty the last tag is in its output cycle,
                // so DONE follows the last rd_valid directly.
                if (!tag_vld_q[0]) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        tag_vld_d  = {tag_vld_q[0], tag_in_vld};
        tag_last_d = {tag_last_q[0], tag_in_last};
        tag_idx_d  = {tag_idx_q[0], tag_in_idx};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wait_q       <= 1'b0;
            addr_q       <= '0;
            cell_count_q <= '0;
            count_err_q  <= 1'b0;
            wr_pend_q    <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            tag_vld_q    <= '0;
            tag_last_q   <= '0;
            tag_idx_q    <= '0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            addr_q       <= addr_d;
            cell_count_q <= cell_count_d;
            count_err_q  <= count_err_d;
            wr_pend_q    <= wr_pend_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            tag_vld_q    <= tag_vld_d;
            tag_last_q   <= tag_last_d;
            tag_idx_q    <= tag_idx_d;
        end
    end

    assign rd_busy    = (state_q != IDLE);
    assign rd_done    = (state_q == DONE);
    assign rd_valid   = tag_vld_q[1];
    assign rd_index   = tag_idx_q[1];
    assign rd_last    = tag_last_q[1];
    // Qualified so the bus reads zero outside valid beats (and under reset).
    assign rd_data    = tag_vld_q[1] ? mem_q : '0;
    assign cell_count = cell_count_q;
    assign count_err  = count_err_q;

endmodule

// File: doc/cell_pos_arbiter.md
# cell_pos_arbiter

Sequencing and arbitration controller for one single-port cell position memory (address 0 = particle count, addresses 1..count = {posz, posy, posx}, 2-cycle read latency). It shares that memory between two requesters. The force-evaluation read side gets a full-cell sweep: the count is read first, then every particle is streamed out in address order. The motion-update write side gets single-word write-back. The block sits between the position cache and its cell RAM, one instance per cell.

## Interface
- DATA_WIDTH, 96, position word width {posz, posy, posx}
- ADDR_WIDTH, 8, memory address width
- PARTICLE_NUM, 220, memory depth; highest legal particle address is PARTICLE_NUM-1
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_req  in  1  level request for a full-cell sweep; held until rd_busy rises
- rd_busy  out  1  sweep in progress
- rd_valid  out  1  rd_data/rd_index valid this cycle
- rd_data  out  DATA_WIDTH  particle position
- rd_index  out  ADDR_WIDTH  memory address of rd_data (1..count)
- rd_last  out  1  final particle of sweep, qualified by rd_valid
- rd_done  out  1  one-cycle pulse when the sweep is finished
- cell_count  out  ADDR_WIDTH  count latched during the current/last sweep
- count_err  out  1  sticky flag: stored count exceeded PARTICLE_NUM-1
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_addr  in  ADDR_WIDTH  write address (0 allowed, rewrites count)
- wr_data  in  DATA_WIDTH  write word
- mem_address  out  ADDR_WIDTH  to RAM address
- mem_data  out  DATA_WIDTH  to RAM data
- mem_rden  out  1  to RAM rden
- mem_wren  out  1  to RAM wren
- mem_q  in  DATA_WIDTH  from RAM q, valid 2 cycles after the read is issued

## Operation
- Reset: all outputs 0, state IDLE, read-tag pipeline cleared. Reset mid-sweep aborts the sweep immediately. No rd_done is produced; in-flight mem_q data is discarded.
- FSM states: IDLE, CNT_RD, CNT_WAIT, STREAM, DRAIN, DONE.
- IDLE: wr_ready = !rd_req (combinational). On write handshake, the next cycle drives mem_wren=1, mem_address=wr_addr and mem_data=wr_data. Writes can be accepted back-to-back. If rd_req is high with no handshake this cycle, go to CNT_RD.
- CNT_RD: issue a read of address 0 (mem_rden=1, mem_address=0). rd_busy=1 from this state through DONE.
- CNT_WAIT: 2 cycles. On the second cycle, mem_q is valid: latch cell_count = min(mem_q[ADDR_WIDTH-1:0], PARTICLE_NUM-1). Set count_err if the value was clamped; count_err clears on entry to CNT_RD. If count==0, go to DONE; else go to STREAM.
- STREAM: issue reads of addresses 1..cell_count, one per cycle. Each read carries a tag (valid, index, last) down a 2-stage shift pipeline. After the last address is issued, go to DRAIN.
- DRAIN: wait until the tag pipeline is empty, then go to DONE.
- Tag output stage: rd_valid, rd_index and rd_last are registered from the stage-2 tag. rd_data = mem_q in the same cycle.
- DONE: rd_done=1 for one cycle, then go to IDLE. rd_req is ignored in DONE, and is ignored whenever rd_busy=1.
- wr_ready=0 in every state except IDLE. Write and read never share a memory cycle.

## Timing
- Write: handshake in cycle k, mem_wren in cycle k+1. A read issued in cycle k+2 or later returns the new data.
- Sweep: rd_req sampled high in IDLE at cycle 0.
  - Cycle 1: CNT_RD (address 0 issued).
  - Cycle 3: count latched.
  - Cycle 4: address 1 issued.
  - Cycle 6: first rd_valid.
  - Cycle 5+N: last rd_valid with rd_last.
  - Cycle 6+N: rd_done.
  - Cycle 7+N: IDLE.
  - Total sweep latency 6+N cycles. For N=0, rd_done at cycle 4.
- Throughput: one particle per cycle during STREAM, no bubbles.

## Configuration
- CELL_ARB_WR_PRIO_EN defined: in IDLE, wr_ready=1 unconditionally. A simultaneous rd_req waits until a cycle with wr_valid=0, so motion-update write-back cannot be starved by a held read request.
- CELL_ARB_WR_PRIO_EN undefined: read priority as described in Operation (wr_ready = !rd_req in IDLE).

## Test plan
- Count=3, addresses 1..3 preloaded A, B, C; rd_req at cycle 0 -> rd_valid at cycles 6, 7, 8 with rd_index 1, 2, 3, data A, B, C, rd_last only at cycle 8, rd_done at cycle 9, cell_count=3.
- Count=0 -> no rd_valid, rd_done at cycle 4, rd_busy high in cycles 1–4.
- Write addr 2 = X (handshake cycle k), then sweep with count=2 -> second rd_valid carries X.
- wr_valid and rd_req high together in IDLE.
  - Without macro: wr_ready=0 and the sweep starts.
  - With CELL_ARB_WR_PRIO_EN: the write is accepted first and the sweep starts in the cycle after wr_valid drops.
- Stored count 250 with PARTICLE_NUM=220 -> cell_count=219, count_err=1, 219 rd_valid beats. count_err clears at the next sweep's CNT_RD.
- rst_n asserted during STREAM -> all outputs 0 immediately. No rd_done. A fresh rd_req after release performs a full sweep.
